// File: rtl/logic_unit_arb.sv
// Two-requester round-robin front end for a shared bitwise logic unit.
// Define LOGIC_UNIT_ARB_XOR_EN to enable opcode 11 (XOR); otherwise it flags rsp_err.
module logic_unit_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_id,
    output logic             rsp_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             id_q, id_d;
    logic             err_q, err_d;

    logic             slot_free;
    logic             grant;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] res_z;
    logic             res_err;

    // On a tie the requester not granted last wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end
    end

    assign slot_free  = (state_q == EMPTY) || rsp_ready;
    assign req0_ready = rst_n & slot_free & req0_valid & ~grant;
    assign req1_ready = rst_n & slot_free & req1_valid & grant;
    assign accept     = req0_ready | req1_ready;

    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    always_comb begin
        res_z   = '0;
        res_err = 1'b0;
        unique case (sel_op)
            2'b00: res_z = ~sel_a;
            2'b01: res_z = sel_a & sel_b;
            2'b10: res_z = sel_a | sel_b;
            2'b11: begin
`ifdef LOGIC_UNIT_ARB_XOR_EN
                res_z   = sel_a ^ sel_b;
                res_err = 1'b0;
`else
                res_z   = '0;
                res_err = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        z_d     = z_q;
        id_d    = id_q;
        err_d   = err_q;
        if (accept) begin
            state_d = FULL;
            last_d  = grant;
            z_d     = res_z;
            id_d    = grant;
            err_d   = res_err;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q  <= 1'b1;
            z_q     <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            z_q     <= z_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_z     = z_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_logic_unit_arb.sv
// Scoreboard bench for logic_unit_arb: directed vectors, queue-based
// response checking in a separate monitor process.
module tb_logic_unit_arb;

    typedef struct {
        logic        id;
        logic [31:0] z;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [1:0]  req0_op = 2'b00;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [1:0]  req1_op = 2'b00;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_z;
    logic        rsp_id;
    logic        rsp_err;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;

    logic        stall_prev = 1'b0;
    logic [31:0] hold_z;
    logic        hold_id;
    logic        hold_err;

`ifdef LOGIC_UNIT_ARB_XOR_EN
    localparam logic [31:0] XOR_Z = 32'h00000001;
    localparam logic        XOR_E = 1'b0;
`else
    localparam logic [31:0] XOR_Z = 32'h00000000;
    localparam logic        XOR_E = 1'b1;
`endif

    logic_unit_arb #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_z      (rsp_z),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle; expected ready pattern decides what is queued.
    task automatic cyc(input logic v0, input logic [1:0] o0,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] z0, input logic e0,
                       input logic v1, input logic [1:0] o1,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [31:0] z1, input logic e1,
                       input logic rr, input logic [1:0] erdy);
        exp_t x;
        req0_valid = v0; req0_op = o0;
        req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1;
        req1_a = a1; req1_b = b1;
        rsp_ready = rr;
        @(negedge clk);
        check("ready", {62'd0, req1_ready, req0_ready},
              {62'd0, erdy});
        if (erdy[0]) begin
            x.id = 1'b0; x.z = z0; x.err = e0;
            sb.push_back(x);
        end
        if (erdy[1]) begin
            x.id = 1'b1; x.z = z1; x.err = e1;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, 2'b00, '0, '0, '0, 1'b0,
            1'b0, 2'b00, '0, '0, '0, 1'b0, rr, 2'b00);
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {63'd0, rsp_valid}, 64'd1);
                check("hold_z", {32'd0, rsp_z}, {32'd0, hold_z});
                check("hold_id", {63'd0, rsp_id}, {63'd0, hold_id});
                check("hold_err", {63'd0, rsp_err},
                      {63'd0, hold_err});
            end
            stall_prev <= rsp_valid && !rsp_ready;
            hold_z     <= rsp_z;
            hold_id    <= rsp_id;
            hold_err   <= rsp_err;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
                    check("rsp_z", {32'd0, rsp_z}, {32'd0, e.z});
                    check("rsp_err", {63'd0, rsp_err},
                          {63'd0, e.err});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        req0_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_z", {32'd0, rsp_z}, 64'd0);
        check("rst_id", {63'd0, rsp_id}, 64'd0);
        check("rst_err", {63'd0, rsp_err}, 64'd0);
        check("rst_ready0", {63'd0, req0_ready}, 64'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // Single NOT from req0.
        cyc(1'b1, 2'b00, 32'h00000001, '0, 32'hFFFFFFFE, 1'b0,
            1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b1, 2'b01);
        check("lat_valid", {63'd0, rsp_valid}, 64'd1);
        check("lat_z", {32'd0, rsp_z}, 64'hFFFFFFFE);

        // Both valid: alternate, req1 first since req0 won last.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b01, 32'hFFFF0000, 32'h0F0F0F0F,
                32'h0F0F0000, 1'b0,
                1'b1, 2'b10, 32'h00000010, 32'h80000000,
                32'h80000010, 1'b0,
                1'b1, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle(1'b1);

        // Stall with a held result; pointer must not move.
        cyc(1'b1, 2'b00, 32'hFFFFFFFF, '0, 32'h00000000, 1'b0,
            1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b01, 32'hFFFF0000, 32'h0F0F0F0F,
                32'h0F0F0000, 1'b0,
                1'b1, 2'b10, 32'h00000010, 32'h80000000,
                32'h80000010, 1'b0, 1'b0, 2'b00);
            check("stall_z", {32'd0, rsp_z}, 64'd0);
            check("stall_valid", {63'd0, rsp_valid}, 64'd1);
        end
        cyc(1'b1, 2'b01, 32'hFFFF0000, 32'h0F0F0F0F,
            32'h0F0F0000, 1'b0,
            1'b1, 2'b10, 32'h00000010, 32'h80000000,
            32'h80000010, 1'b0, 1'b1, 2'b10);

        // Opcode 11 and full-width patterns.
        cyc(1'b0, 2'b00, '0, '0, '0, 1'b0,
            1'b1, 2'b11, 32'h00004000, 32'h00004001,
            XOR_Z, XOR_E, 1'b1, 2'b10);
        cyc(1'b1, 2'b10, 32'h00000000, 32'h00000000,
            32'h00000000, 1'b0,
            1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b1, 2'b01);
        cyc(1'b0, 2'b00, '0, '0, '0, 1'b0,
            1'b1, 2'b00, 32'hAAAAAAAA, 32'h12345678,
            32'h55555555, 1'b0, 1'b1, 2'b10);
        cyc(1'b0, 2'b00, '0, '0, '0, 1'b0,
            1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFF, 1'b0, 1'b1, 2'b10);
        idle(1'b1);
        idle(1'b1);

        // Reset while FULL and stalled discards the result.
        cyc(1'b1, 2'b00, 32'h00000000, '0, 32'hFFFFFFFF, 1'b0,
            1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b1, 2'b01);
        idle(1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rstfull_valid", {63'd0, rsp_valid}, 64'd0);
        check("rstfull_rdy", {62'd0, req1_ready, req0_ready}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 2'b10, 32'h0000F000, 32'h0000000F,
            32'h0000F00F, 1'b0,
            1'b1, 2'b01, 32'h0000FFFF, 32'h00FF00FF,
            32'h000000FF, 1'b0, 1'b1, 2'b01);
        idle(1'b1);
        idle(1'b1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_arb.md
LOGIC_UNIT_ARB -- requirements
Module: logic_unit_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of operands and result.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset is asynchronous and active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 offers an operation.
REQ-005 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have port req0_op  input  2  opcode: 00 NOT a, 01 AND, 10 OR, 11 XOR.
REQ-007 SHALL have ports req0_a, req0_b  input  WIDTH  operands; b ignored for NOT.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_op, req1_a, req1_b, identical in direction, width and meaning to requester 0.
REQ-009 SHALL have port rsp_valid  output  1  result slot holds a result.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port rsp_z  output  WIDTH  registered result.
REQ-012 SHALL have port rsp_id  output  1  requester that issued the held result.
REQ-013 SHALL have port rsp_err  output  1  held result came from an unsupported opcode.

Function
REQ-014 SHALL share one bitwise logic unit between both requesters, with a one-entry registered result slot.
REQ-015 SHALL have slot states EMPTY and FULL; rsp_valid = (state == FULL).
REQ-016 slot_free SHALL be EMPTY, or FULL with rsp_ready high.
REQ-017 SHALL select grant: only one valid -> that requester; both valid -> the one not granted last (round-robin); none -> no grant.
REQ-018 reqN_ready SHALL be high only when slot_free, reqN_valid and grant == N (combinational, at most one ready per cycle).
REQ-019 On accept (valid & ready), the slot SHALL load rsp_z, rsp_id and rsp_err on the next edge: latency exactly 1 cycle, state FULL.
REQ-020 FULL with rsp_ready and no accept SHALL go to EMPTY; FULL with rsp_ready and an accept SHALL stay FULL with new data (back-to-back, full throughput).
REQ-021 FULL with rsp_ready low SHALL hold rsp_z, rsp_id and rsp_err stable; both ready outputs low.
REQ-022 The last-grant pointer SHALL update only on accept, never on a non-accepted request.
REQ-023 Operations SHALL be bitwise over all WIDTH bits with no carry, and rsp_err SHALL be 0 for supported opcodes.

Reset
REQ-024 Asserting rst_n low SHALL immediately force: state EMPTY, rsp_valid 0, rsp_z 0, rsp_id 0, rsp_err 0, last-grant = 1 (requester 0 wins first tie).
REQ-025 Reset during FULL SHALL discard the held result; no response for it is ever produced.
REQ-026 ready outputs SHALL be 0 while rst_n is low; normal operation SHALL start on the first edge after release.

Configuration
REQ-027 Macro LOGIC_UNIT_ARB_XOR_EN SHALL control XOR support.
REQ-028 With LOGIC_UNIT_ARB_XOR_EN defined, opcode 11 SHALL yield a ^ b with rsp_err 0.
REQ-029 Without it, opcode 11 SHALL still be accepted, and SHALL yield rsp_z = 0 with rsp_err = 1; no XOR logic is synthesized.

Verification
REQ-030 req0 NOT with a=32'h00000001, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_z=32'hFFFFFFFE, rsp_id=0.
REQ-031 Both valid every cycle, req0 AND a=32'hFFFF0000 b=32'h0F0F0F0F, req1 OR a=32'h00000010 b=32'h80000000, rsp_ready=1 -> responses alternate: id0 32'h0F0F0000, id1 32'h80000010, one per cycle.
REQ-032 rsp_ready=0 for 3 cycles after a NOT of 32'hFFFFFFFF -> rsp_z holds 32'h00000000, both ready low; on rsp_ready=1 the next request is accepted the same cycle.
REQ-033 req1 op 11, a=32'h00004000, b=32'h00004001 -> with macro rsp_z=32'h00000001, rsp_err=0; without macro rsp_z=0, rsp_err=1.
REQ-034 rst_n low while FULL with rsp_ready=0 -> rsp_valid drops at once; after release a tie grants req0 first.
